cap_touch_decoder: RTL and testbench

- Consumes the per-pad charge-time counts from the capacitive sensor array and turns them into debounced touch states and single-cycle press events for the whack-a-mole game logic.
- Samples all channels once per falling edge of the sensor trigger.
- Calibrates a per-channel untouched baseline after reset.
- Applies hysteresis thresholds and a consecutive-sample debounce to each channel.

---
 rtl/cap_touch_decoder.sv | 178 +++++++++++++++++
 tb/tb_cap_touch_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cap_touch_decoder.sv
// Capacitive touch decoder: per-channel baseline calibration, hysteresis and debounce, press events.
// Optional macro CAP_TOUCH_BASELINE_TRACK_EN enables slow baseline drift tracking on untouched channels.
module cap_touch_decoder #(
    parameter int NUM_CH     = 9,
    parameter int CNT_W      = 32,
    parameter int CAL_LOG2   = 4,
    parameter int TOUCH_TH   = 200,
    parameter int RELEASE_TH = 100,
    parameter int DEBOUNCE   = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    sensor_trigger,
    input  logic [NUM_CH*CNT_W-1:0] counts,
    output logic                    calibrated,
    output logic [NUM_CH-1:0]       touched,
    output logic                    press_valid,
    output logic [3:0]              press_index,
    output logic                    overrun
);

    localparam int ACC_W = CNT_W + CAL_LOG2;
    localparam logic [CAL_LOG2:0] CAL_CNT_LAST = (CAL_LOG2+1)'((1 << CAL_LOG2) - 1);
    localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

    typedef enum logic [2:0] {CAL_WAIT, CAL_ACC, IDLE, SCAN, REPORT} state_t;

    state_t             state;
    logic               trig_q;
    logic [3:0]         ch;
    logic [CAL_LOG2:0]  cal_cnt;
    logic [CNT_W-1:0]   snap     [NUM_CH];
    logic [ACC_W-1:0]   acc      [NUM_CH];
    logic [CNT_W-1:0]   baseline [NUM_CH];
    logic [3:0]         deb      [NUM_CH];
    logic [NUM_CH-1:0]  st;
    logic [NUM_CH-1:0]  rise;

    logic               fall;
    logic               last_ch;
    logic [CNT_W-1:0]   cur_snap;
    logic [CNT_W-1:0]   cur_base;
    logic [CNT_W-1:0]   delta;
    logic               agree;
    logic [3:0]         deb_inc;
    logic               flip;
    logic [NUM_CH-1:0]  st_nxt;
    logic [NUM_CH-1:0]  rise_nxt;
    logic [3:0]         first_idx;
    logic [ACC_W-1:0]   acc_sum;

    // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
    always_comb begin
        fall      = trig_q & ~sensor_trigger;
        last_ch   = (ch == LAST_CH);
        cur_snap  = snap[ch];
        cur_base  = baseline[ch];
        delta     = (cur_snap > cur_base) ? cur_snap - cur_base : '0;
        agree     = st[ch] ? (delta < CNT_W'(RELEASE_TH)) : (delta >= CNT_W'(TOUCH_TH));
        deb_inc   = deb[ch] + 4'd1;
        flip      = agree && (deb_inc == 4'(DEBOUNCE));
        acc_sum   = acc[ch] + ACC_W'(cur_snap);
        st_nxt    = st;
        rise_nxt  = rise;
        if (flip) begin
            st_nxt[ch] = ~st[ch];
            if (!st[ch])
                rise_nxt[ch] = 1'b1;
        end
        // Scan from the top down so the lowest flagged channel wins.
        first_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (rise_nxt[i])
                first_idx = 4'(i);
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking here would create order-dependent races.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= CAL_WAIT;
            trig_q      <= 1'b0;
            ch          <= '0;
            cal_cnt     <= '0;
            st          <= '0;
            rise        <= '0;
            calibrated  <= 1'b0;
            touched     <= '0;
            press_valid <= 1'b0;
            press_index <= '0;
            overrun     <= 1'b0;
            // NOTE: the small per-channel arrays are reset on purpose: recalibration must start from zero.
            for (int i = 0; i < NUM_CH; i++) begin
                snap[i]     <= '0;
                acc[i]      <= '0;
                baseline[i] <= '0;
                deb[i]      <= '0;
            end
        end else begin
            trig_q      <= sensor_trigger;
            press_valid <= 1'b0;
            case (state)
                CAL_WAIT: begin
                    if (fall) begin
                        for (int i = 0; i < NUM_CH; i++)
                            snap[i] <= counts[i*CNT_W +: CNT_W];
                        ch    <= '0;
                        state <= CAL_ACC;
                    end
                end
                CAL_ACC: begin
                    if (fall)
                        overrun <= 1'b1;
                    acc[ch] <= acc_sum;
                    if (last_ch) begin
                        cal_cnt <= cal_cnt + 1'b1;
                        if (cal_cnt == CAL_CNT_LAST) begin
                            // The last channel's sum is still in flight, so use acc_sum for it.
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (i == NUM_CH - 1)
                                    baseline[i] <= CNT_W'(acc_sum >> CAL_LOG2);
                                else
                                    baseline[i] <= CNT_W'(acc[i] >> CAL_LOG2);
                            end
                            calibrated <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= CAL_WAIT;
                        end
                    end else begin
                        ch <= ch + 4'd1;
                    end
                end
                IDLE: begin
                    if (fall) begin
                        for (int i = 0; i < NUM_CH; i++)
                            snap[i] <= counts[i*CNT_W +: CNT_W];
                        ch    <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (fall)
                        overrun <= 1'b1;
                    st      <= st_nxt;
                    rise    <= rise_nxt;
                    deb[ch] <= (flip || !agree) ? 4'd0 : deb_inc;
`ifdef CAP_TOUCH_BASELINE_TRACK_EN
                    if (!st[ch] && (delta < CNT_W'(RELEASE_TH))) begin
                        if (cur_snap > cur_base)
                            baseline[ch] <= cur_base + 1'b1;
                        else if (cur_snap < cur_base)
                            baseline[ch] <= cur_base - 1'b1;
                    end
`endif
                    if (last_ch) begin
                        // Outputs are loaded on entry to REPORT so they are valid during that cycle.
                        touched <= st_nxt;
                        if (|rise_nxt) begin
                            press_valid <= 1'b1;
                            press_index <= first_idx;
                        end
                        state <= REPORT;
                    end else begin
                        ch <= ch + 4'd1;
                    end
                end
                REPORT: begin
                    if (fall)
                        overrun <= 1'b1;
                    rise  <= '0;
                    state <= IDLE;
                end
                default: state <= CAL_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_cap_touch_decoder.sv
// Directed bench for cap_touch_decoder: calibration, press, hysteresis, bounce, overrun, reset, tracking.
module tb_cap_touch_decoder;

    localparam int NUM_CH = 9;
    localparam int CNT_W  = 32;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    sensor_trigger = 1'b0;
    logic [NUM_CH*CNT_W-1:0] counts;
    logic                    calibrated;
    logic [NUM_CH-1:0]       touched;
    logic                    press_valid;
    logic [3:0]              press_index;
    logic                    overrun;

    logic [CNT_W-1:0] ch_val [NUM_CH];
    int n_checks = 0;
    int n_bad    = 0;
    int pulses;
    int pulse_sum;
    logic [3:0] idx;

    cap_touch_decoder #(.CAL_LOG2(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .sensor_trigger (sensor_trigger),
        .counts         (counts),
        .calibrated     (calibrated),
        .touched        (touched),
        .press_valid    (press_valid),
        .press_index    (press_index),
        .overrun        (overrun)
    );

    always #10 clock = ~clock;

    always_comb begin
        counts = '0;
        for (int i = 0; i < NUM_CH; i++)
            counts[i*CNT_W +: CNT_W] = ch_val[i];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One trigger pulse, then watch long enough for a full scan and report.
    task automatic sample(output int np, output logic [3:0] pidx);
        np   = 0;
        pidx = '0;
        @(negedge clock) sensor_trigger = 1'b1;
        @(negedge clock) sensor_trigger = 1'b0;
        repeat (16) begin
            @(negedge clock);
            if (press_valid) begin
                np++;
                pidx = press_index;
            end
        end
    endtask

    task automatic set_all(input logic [CNT_W-1:0] v);
        for (int i = 0; i < NUM_CH; i++)
            ch_val[i] = v;
    endtask

    initial begin
        set_all(32'd1000);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_calibrated", 32'(calibrated), 0);
        check("rst_touched", 32'(touched), 0);
        check("rst_press_valid", 32'(press_valid), 0);
        check("rst_press_index", 32'(press_index), 0);
        check("rst_overrun", 32'(overrun), 0);

        // Calibration: four samples of 1000
        pulse_sum = 0;
        repeat (3) begin
            sample(pulses, idx);
            pulse_sum += pulses;
        end
        check("cal_not_yet", 32'(calibrated), 0);
        sample(pulses, idx);
        pulse_sum += pulses;
        check("cal_done", 32'(calibrated), 1);
        check("cal_touched", 32'(touched), 0);
        check("cal_no_press", 32'(pulse_sum), 0);

        // Press on channel 4
        ch_val[4] = 32'd1300;
        sample(pulses, idx);
        check("press_s1_touched", 32'(touched), 0);
        sample(pulses, idx);
        check("press_s2_touched", 32'(touched), 0);
        check("press_s2_pulses", 32'(pulses), 0);
        sample(pulses, idx);
        check("press_touched", 32'(touched), 32'h010);
        check("press_pulses", 32'(pulses), 1);
        check("press_index", 32'(idx), 4);

        // Hysteresis band holds, then release
        ch_val[4] = 32'd1150;
        pulse_sum = 0;
        repeat (5) begin
            sample(pulses, idx);
            pulse_sum += pulses;
        end
        check("hyst_touched", 32'(touched), 32'h010);
        ch_val[4] = 32'd1050;
        repeat (2) begin
            sample(pulses, idx);
            pulse_sum += pulses;
        end
        check("rel_s2_touched", 32'(touched), 32'h010);
        sample(pulses, idx);
        pulse_sum += pulses;
        check("rel_touched", 32'(touched), 0);
        check("rel_no_press", 32'(pulse_sum), 0);
        check("rel_index_held", 32'(press_index), 4);
        ch_val[4] = 32'd1000;

        // Simultaneous press on channels 2 and 7
        ch_val[2] = 32'd1300;
        ch_val[7] = 32'd1300;
        sample(pulses, idx);
        sample(pulses, idx);
        check("sim_s2_touched", 32'(touched), 0);
        sample(pulses, idx);
        check("sim_touched", 32'(touched), 32'h084);
        check("sim_pulses", 32'(pulses), 1);
        check("sim_index", 32'(idx), 2);

        // Bounce on channel 5 never settles
        pulse_sum = 0;
        ch_val[5] = 32'd1300; sample(pulses, idx); pulse_sum += pulses;
        ch_val[5] = 32'd1300; sample(pulses, idx); pulse_sum += pulses;
        ch_val[5] = 32'd1000; sample(pulses, idx); pulse_sum += pulses;
        ch_val[5] = 32'd1300; sample(pulses, idx); pulse_sum += pulses;
        check("bounce_touched", 32'(touched), 32'h084);
        check("bounce_no_press", 32'(pulse_sum), 0);
        ch_val[5] = 32'd1000;
        ch_val[2] = 32'd1000;
        ch_val[7] = 32'd1000;
        repeat (3) sample(pulses, idx);
        check("sim_release", 32'(touched), 0);

        // Saturation on channel 0 and a dropped trigger during SCAN
        ch_val[0] = 32'd800;
        check("ovr_before", 32'(overrun), 0);
        @(negedge clock) sensor_trigger = 1'b1;
        @(negedge clock) sensor_trigger = 1'b0;
        @(negedge clock) begin
            sensor_trigger = 1'b1;
            ch_val[3] = 32'd1300;
        end
        @(negedge clock);
        @(negedge clock) sensor_trigger = 1'b0;
        repeat (16) @(negedge clock);
        check("ovr_set", 32'(overrun), 1);
        sample(pulses, idx);
        sample(pulses, idx);
        check("ovr_dropped_sample", 32'(touched), 0);
        sample(pulses, idx);
        check("ovr_ch3_touched", 32'(touched), 32'h008);
        check("ovr_ch3_index", 32'(idx), 3);
        check("ovr_sticky", 32'(overrun), 1);

        // Reset in the middle of a scan
        @(negedge clock) sensor_trigger = 1'b1;
        @(negedge clock) sensor_trigger = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock) reset = 1'b1;
        @(negedge clock);
        check("mid_rst_calibrated", 32'(calibrated), 0);
        check("mid_rst_touched", 32'(touched), 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        check("mid_rst_index", 32'(press_index), 0);
        check("mid_rst_press_valid", 32'(press_valid), 0);
        reset = 1'b0;
        set_all(32'd1000);
        pulse_sum = 0;
        repeat (3) begin
            sample(pulses, idx);
            pulse_sum += pulses;
        end
        check("recal_not_yet", 32'(calibrated), 0);
        sample(pulses, idx);
        pulse_sum += pulses;
        check("recal_done", 32'(calibrated), 1);
        check("recal_touched", 32'(touched), 0);
        check("recal_no_press", 32'(pulse_sum), 0);

        // Drift on channel 1: tracked baseline follows it, a frozen one does not
        ch_val[1] = 32'd1050;
        pulse_sum = 0;
        repeat (50) begin
            sample(pulses, idx);
            pulse_sum += pulses;
        end
        check("drift_no_press", 32'(pulse_sum), 0);
        check("drift_touched", 32'(touched), 0);
        ch_val[1] = 32'd1249;
        pulse_sum = 0;
        repeat (3) begin
            sample(pulses, idx);
            pulse_sum += pulses;
        end
`ifdef CAP_TOUCH_BASELINE_TRACK_EN
        check("track_touched", 32'(touched), 0);
        check("track_no_press", 32'(pulse_sum), 0);
`else
        check("frozen_touched", 32'(touched), 32'h002);
        check("frozen_press", 32'(pulse_sum), 1);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
